// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the instruction ROM: start/run/done control,
// linear fetch, absolute and relative branches, stall, halt and error detection.
module fetch_sequencer #(
    parameter int          PC_W       = 8,
    parameter int unsigned START_ADDR = 0,
    parameter int          CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic             stall,
    input  logic             halt,
    input  logic             branch_taken,
    input  logic             branch_rel,
    input  logic [PC_W-1:0]  branch_target,
    output logic [PC_W-1:0]  prog_ctr,
    output logic             running,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    state_t                 state, state_nxt;
    logic [PC_W-1:0]        pc_nxt;
    logic                   err_nxt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic signed [PC_W:0]   rel_sum;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Relative target at one extra bit: any result with the top bit set is
    // either negative or beyond the last ROM address.
    assign rel_sum = signed'({1'b0, prog_ctr}) +
                     signed'({branch_target[PC_W-1], branch_target});

    always_comb begin
        state_nxt = state;
        pc_nxt    = prog_ctr;
        err_nxt   = err;
        cnt_nxt   = instr_count;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = START_PC;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                end
            end
            RUN: begin
                if (!stall) begin
                    cnt_nxt = sat_inc(instr_count);
                    if (halt) begin
                        state_nxt = DONE;
                    end else if (branch_taken && !branch_rel) begin
                        pc_nxt = branch_target;
                    end else if (branch_taken) begin
                        if (rel_sum[PC_W]) begin
                            state_nxt = DONE;
                            err_nxt   = 1'b1;
                        end else begin
                            pc_nxt = rel_sum[PC_W-1:0];
                        end
                    end else if (&prog_ctr) begin
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                    end else begin
                        pc_nxt = prog_ctr + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            prog_ctr    <= START_PC;
            err         <= 1'b0;
            instr_count <= '0;
        end else begin
            state       <= state_nxt;
            prog_ctr    <= pc_nxt;
            err         <= err_nxt;
            instr_count <= cnt_nxt;
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule
